// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read memory between the host path and N engine lanes.
// Host has priority up to HOST_MAX consecutive grants while lanes wait; lanes rotate round-robin.
module mem_port_arbiter #(
    parameter int N_LANES  = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int HOST_MAX = 4
) (
    input  logic                        tck,
    input  logic                        aclr,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [DATA_W-1:0]           host_wdata,
    output logic                        host_gnt,
    output logic                        host_rvalid,
    output logic [DATA_W-1:0]           host_rdata,
    input  logic [N_LANES-1:0]          lane_req,
    input  logic [N_LANES-1:0]          lane_we,
    input  logic [N_LANES*ADDR_W-1:0]   lane_addr,
    input  logic [N_LANES*DATA_W-1:0]   lane_wdata,
    output logic [N_LANES-1:0]          lane_gnt,
    output logic [N_LANES-1:0]          lane_rvalid,
    output logic [DATA_W-1:0]           lane_rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int LID_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int RUN_W = $clog2(HOST_MAX + 1);

    logic [RUN_W-1:0]  host_run_q, host_run_d;
    logic [LID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              tag0_v_q, tag0_v_d, tag0_host_q, tag0_host_d;
    logic [LID_W-1:0]  tag0_id_q, tag0_id_d;
    logic              tag1_v_q, tag1_host_q;
    logic [LID_W-1:0]  tag1_id_q;
    logic              busy_q, busy_d;

    logic              any_lane, host_win, lane_hit, lane_win, sel_we;
    logic [LID_W-1:0]  lane_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    int                j;

    // Winner selection: host unless its run limit is reached with lanes waiting,
    // otherwise the first requesting lane scanning upward from rr_ptr.
    always_comb begin
        any_lane = |lane_req;
        host_win = host_req && (!any_lane || (host_run_q < RUN_W'(HOST_MAX)));
        lane_hit = 1'b0;
        lane_sel = '0;
        j        = 0;
        for (int k = 0; k < N_LANES; k++) begin
            j = (int'(rr_ptr_q) + k) % N_LANES;
            if (!lane_hit && lane_req[j]) begin
                lane_hit = 1'b1;
                lane_sel = LID_W'(j);
            end
        end
        lane_win  = !host_win && lane_hit;
        sel_we    = host_win ? host_we    : lane_we[lane_sel];
        sel_addr  = host_win ? host_addr  : lane_addr[lane_sel*ADDR_W +: ADDR_W];
        sel_wdata = host_win ? host_wdata : lane_wdata[lane_sel*DATA_W +: DATA_W];
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (host_win || lane_win) begin
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
        end

        rr_ptr_d = rr_ptr_q;
        if (lane_win)
            rr_ptr_d = (int'(lane_sel) == N_LANES - 1) ? '0 : lane_sel + 1'b1;

        host_run_d = host_run_q;
        if (!any_lane || lane_win)
            host_run_d = '0;
        else if (host_win && (host_run_q < RUN_W'(HOST_MAX)))
            host_run_d = host_run_q + 1'b1;

        tag0_v_d    = (host_win || lane_win) && !sel_we;
        tag0_host_d = host_win;
        tag0_id_d   = lane_sel;

        busy_d = tag0_v_q || tag1_v_q || host_req || any_lane;
    end

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            host_run_q  <= '0;
            rr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag0_v_q    <= 1'b0;
            tag0_host_q <= 1'b0;
            tag0_id_q   <= '0;
            tag1_v_q    <= 1'b0;
            tag1_host_q <= 1'b0;
            tag1_id_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            host_run_q  <= host_run_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag0_v_q    <= tag0_v_d;
            tag0_host_q <= tag0_host_d;
            tag0_id_q   <= tag0_id_d;
            tag1_v_q    <= tag0_v_q;
            tag1_host_q <= tag0_host_q;
            tag1_id_q   <= tag0_id_q;
            busy_q      <= busy_d;
        end
    end

    assign host_gnt    = host_win;
    assign lane_gnt    = lane_win ? (N_LANES'(1) << lane_sel) : '0;
    assign host_rvalid = tag1_v_q && tag1_host_q;
    assign lane_rvalid = (tag1_v_q && !tag1_host_q) ? (N_LANES'(1) << tag1_id_q) : '0;
    assign host_rdata  = mem_rdata;
    assign lane_rdata  = mem_rdata;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants per step, a shadow memory and a
// queue of expected read returns checked two cycles after each read grant.
module tb_mem_port_arbiter;

    localparam int NL = 4;

    logic              tck = 1'b0;
    logic              aclr;
    logic              host_req, host_we, host_gnt, host_rvalid;
    logic [7:0]        host_addr, host_wdata, host_rdata;
    logic [NL-1:0]     lane_req, lane_we, lane_gnt, lane_rvalid;
    logic [NL*8-1:0]   lane_addr, lane_wdata;
    logic [7:0]        lane_rdata;
    logic              mem_we, busy;
    logic [7:0]        mem_addr, mem_wdata, mem_rdata;
    logic [7:0]        l_addr [NL];
    logic [7:0]        l_wdata [NL];

    typedef struct {
        bit         is_host;
        int         lane;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] shadow [256];
    logic [7:0] mem [256];
    bit         init_done;
    int         cyc;
    int         vectors;
    int         miscompares;
    logic       exp_we;
    logic [7:0] exp_addr, exp_wdata;

    assign lane_addr  = {l_addr[3], l_addr[2], l_addr[1], l_addr[0]};
    assign lane_wdata = {l_wdata[3], l_wdata[2], l_wdata[1], l_wdata[0]};

    mem_port_arbiter #(.N_LANES(NL), .ADDR_W(8), .DATA_W(8), .HOST_MAX(4)) dut (
        .tck(tck), .aclr(aclr),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .lane_req(lane_req), .lane_we(lane_we), .lane_addr(lane_addr), .lane_wdata(lane_wdata),
        .lane_gnt(lane_gnt), .lane_rvalid(lane_rvalid), .lane_rdata(lane_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 tck = ~tck;

    always @(posedge tck) cyc <= cyc + 1;

    function automatic logic [7:0] initVal(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Synchronous-read 256x8 macro model, preloaded on its first clock edge.
    always @(posedge tck) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
            init_done <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic compare(input logic [31:0] got, input logic [31:0] exp, input string tag);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic hreq, input logic hwe, input logic [7:0] ha,
                                 input logic [7:0] hd, input logic [3:0] lr, input logic [3:0] lw);
        host_req   = hreq;
        host_we    = hwe;
        host_addr  = ha;
        host_wdata = hd;
        lane_req   = lr;
        lane_we    = lw;
    endtask

    // Record the command the winner should put on the memory bus next cycle.
    task automatic commit(input bit is_host, input int lane, input logic we,
                          input logic [7:0] a, input logic [7:0] d);
        exp_we    = we;
        exp_addr  = a;
        exp_wdata = d;
        if (we) shadow[a] = d;
        else    sb.push_back('{is_host, lane, shadow[a], cyc + 2});
    endtask

    task automatic checkOutput(input logic exp_hg, input logic [3:0] exp_lg, input string tag);
        logic       eh;
        logic [3:0] el;
        logic [7:0] ed;
        exp_t       e;
        @(negedge tck);
        eh = 1'b0;
        el = '0;
        ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.is_host) eh = 1'b1;
            else           el[e.lane] = 1'b1;
            ed = e.data;
        end
        compare(32'(host_rvalid), 32'(eh), {tag, "/host_rvalid"});
        compare(32'(lane_rvalid), 32'(el), {tag, "/lane_rvalid"});
        if (eh)  compare(32'(host_rdata), 32'(ed), {tag, "/host_rdata"});
        if (|el) compare(32'(lane_rdata), 32'(ed), {tag, "/lane_rdata"});
        compare(32'(host_gnt), 32'(exp_hg), {tag, "/host_gnt"});
        compare(32'(lane_gnt), 32'(exp_lg), {tag, "/lane_gnt"});
        compare(32'(mem_we), 32'(exp_we), {tag, "/mem_we"});
        compare(32'(mem_addr), 32'(exp_addr), {tag, "/mem_addr"});
        compare(32'(mem_wdata), 32'(exp_wdata), {tag, "/mem_wdata"});
        if (exp_hg) begin
            commit(1'b1, 0, host_we, host_addr, host_wdata);
        end else if (|exp_lg) begin
            for (int k = 0; k < NL; k++)
                if (exp_lg[k]) commit(1'b0, k, lane_we[k], l_addr[k], l_wdata[k]);
        end else begin
            exp_we = 1'b0;
        end
        @(posedge tck);
        #1;
    endtask

    task automatic checkReset(input string tag);
        compare(32'(mem_we), 32'd0, {tag, "/mem_we"});
        compare(32'(mem_addr), 32'd0, {tag, "/mem_addr"});
        compare(32'(mem_wdata), 32'd0, {tag, "/mem_wdata"});
        compare(32'(host_rvalid), 32'd0, {tag, "/host_rvalid"});
        compare(32'(lane_rvalid), 32'd0, {tag, "/lane_rvalid"});
        compare(32'(busy), 32'd0, {tag, "/busy"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        aclr        = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = initVal(i);
        for (int i = 0; i < NL; i++) begin
            l_addr[i]  = 8'h20 + 8'(i);
            l_wdata[i] = 8'h00;
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        exp_we    = 1'b0;
        exp_addr  = 8'h00;
        exp_wdata = 8'h00;

        @(negedge tck);
        checkReset("reset");
        @(posedge tck);
        #1 aclr = 1'b0;

        // Host write 0x12 <- 0xA5 then read it back.
        applyStimulus(1, 1, 8'h12, 8'hA5, 4'h0, 4'h0);
        checkOutput(1, 4'h0, "host_wr");
        applyStimulus(1, 0, 8'h12, 8'h00, 4'h0, 4'h0);
        checkOutput(1, 4'h0, "host_rd");
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "host_drain");

        // All lanes reading continuously: strict rotation from lane 0.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 4'hF, 4'h0);
            checkOutput(0, 4'(1 << (k % NL)), "rr");
            if (k == 2) compare(32'(busy), 32'd1, "busy_active");
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "rr_drain");

        // Host and lane 2 contending: four host grants then one lane grant.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 0, 8'h12, 8'h00, 4'b0100, 4'h0);
            if (k % 5 == 4) checkOutput(0, 4'b0100, "starve_lane");
            else            checkOutput(1, 4'h0, "starve_host");
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "starve_drain");

        // Lane 1 writes 0x40, lane 3 reads it the very next cycle.
        l_addr[1]  = 8'h40;
        l_wdata[1] = 8'h3C;
        applyStimulus(0, 0, 8'h00, 8'h00, 4'b0010, 4'b0010);
        checkOutput(0, 4'b0010, "raw_wr");
        l_addr[3] = 8'h40;
        applyStimulus(0, 0, 8'h00, 8'h00, 4'b1000, 4'h0);
        checkOutput(0, 4'b1000, "raw_rd");
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "raw_drain");

        // Lane 0 offers a write to 0x77 but withdraws while the host holds priority.
        l_addr[0]  = 8'h77;
        l_wdata[0] = 8'hEE;
        applyStimulus(1, 0, 8'h12, 8'h00, 4'b0001, 4'b0001);
        checkOutput(1, 4'h0, "drop_host0");
        applyStimulus(1, 0, 8'h12, 8'h00, 4'h0, 4'h0);
        checkOutput(1, 4'h0, "drop_host1");
        applyStimulus(1, 0, 8'h77, 8'h00, 4'h0, 4'h0);
        checkOutput(1, 4'h0, "drop_verify");
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "drop_drain");

        // Advance rr_ptr away from lane 0, then reset with a host read in flight.
        applyStimulus(0, 0, 8'h00, 8'h00, 4'b0100, 4'h0);
        checkOutput(0, 4'b0100, "pre_rst_l2");
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (2) checkOutput(0, 4'h0, "pre_rst_drain");
        applyStimulus(1, 0, 8'h12, 8'h00, 4'h0, 4'h0);
        checkOutput(1, 4'h0, "rst_host_rd");
        aclr = 1'b1;
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        sb.delete();
        exp_we    = 1'b0;
        exp_addr  = 8'h00;
        exp_wdata = 8'h00;
        @(negedge tck);
        checkReset("mid_reset");
        compare(32'(host_gnt), 32'd0, "mid_reset/host_gnt");
        @(negedge tck);
        compare(32'(host_rvalid), 32'd0, "mid_reset/no_rvalid");
        @(posedge tck);
        #1 aclr = 1'b0;

        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 4'hF, 4'h0);
            checkOutput(0, 4'(1 << k), "post_rst");
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
        repeat (5) checkOutput(0, 4'h0, "final_drain");
        compare(32'(busy), 32'd0, "busy_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 256×8 synchronous-read image memory between the JTAG host path and N downscaler engine lanes. Each cycle it picks at most one requester, drives one registered memory command, and routes read data back to the requester that issued it. The host has priority, bounded by a starvation limit; lanes are served round-robin. It sits between the JTAG memory register path, the parallel bilinear lanes and the memory macro.

## Interface
- N_LANES, 4, number of engine requesters (2..8)
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- HOST_MAX, 4, max consecutive host grants while any lane is pending (≥1)

- tck  in  1  single clock, all logic on rising edge
- aclr  in  1  asynchronous, active-high reset
- host_req  in  1  host access request, level
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle (combinational)
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- lane_req  in  N_LANES  per-lane request, level
- lane_we  in  N_LANES  per-lane write enable
- lane_addr  in  N_LANES*ADDR_W  packed, lane i at [i*ADDR_W +: ADDR_W]
- lane_wdata  in  N_LANES*DATA_W  packed likewise
- lane_gnt  out  N_LANES  one-hot or zero, combinational
- lane_rvalid  out  N_LANES  per-lane read data valid
- lane_rdata  out  DATA_W  shared read data bus, qualified by lane_rvalid
- mem_we  out  1  registered memory write strobe
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_addr is presented
- busy  out  1  registered: any read in flight or any request pending

## Operation
- Handshake: requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle; access is committed at that cycle's rising edge. Requester may present a new request or drop req in the next cycle.
- Selection, each cycle:
  - host_req and (no lane_req or host_run < HOST_MAX) → host wins.
  - Otherwise, lane wins: first requesting lane at or after rr_ptr, wrapping modulo N_LANES.
  - At most one gnt bit high across host_gnt and lane_gnt.
- host_run counter: increments on each host grant while any lane_req is high, saturating at HOST_MAX. Clears on any lane grant or whenever no lane_req is high.
- rr_ptr: after granting lane i, becomes (i+1) mod N_LANES. Unchanged on host grant or idle.
- Command register: on grant, mem_addr/mem_wdata ← winner's inputs and mem_we ← winner's we. On idle, mem_we ← 0 and addr/wdata hold.
- Read tag pipeline: 2 stages of {valid, is_host, lane_id}. Stage 0 is loaded on a read grant; stage 1 ← stage 0.
  - Stage 1 valid drives host_rvalid or lane_rvalid[lane_id].
  - host_rdata and lane_rdata both = mem_rdata.
- Writes produce no rvalid.
- busy = any tag stage valid or any req high, registered.

## Timing
- Reset (aclr=1, async): mem_we=0, mem_addr=0, mem_wdata=0, all rvalid=0, busy=0, rr_ptr=0, host_run=0, tag pipeline cleared.
- Reset mid-operation drops in-flight reads; no rvalid is emitted for them after release.
- gnt is combinational from req in cycle t; this is the grant cycle.
- Memory command is presented in t+1.
- Read data and rvalid appear in t+2: read latency = 2 cycles from grant. rvalid is a 1-cycle pulse per read.
- Throughput: one access per cycle, back-to-back grants allowed, including consecutive reads from different requesters.
- Read after write, same address, granted in consecutive cycles: read returns the new data.
- Requester dropping req before gnt: no access, no state change except selection in that cycle.

## Test plan
- Reset then single host write 0x12←0xA5, followed by host read 0x12 → host_gnt in grant cycle; mem_we=1, addr=0x12 in t+1; host_rvalid with rdata=0xA5 exactly 2 cycles after the read grant.
- All 4 lanes request reads continuously, no host → grants cycle lane0,1,2,3,0… one per cycle; each lane_rvalid pulses 2 cycles after its grant with correct data.
- Host and lane2 both request continuously, HOST_MAX=4 → grants host×4, lane2, host×4, lane2 …; host_run clears on each lane grant.
- Lane1 write 0x40←0x3C granted in cycle t, lane3 read 0x40 granted in t+1 → lane_rvalid[3] in t+3 with rdata=0x3C.
- aclr asserted one cycle after a host read grant → no host_rvalid afterwards; all outputs at reset values; first post-reset lane grant goes to lane0.
- Lane0 raises req then drops it before grant while host holds priority → lane0 never granted, mem_we never driven for lane0's address.
